// File: rtl/u_seqdiv_rst.sv
// rtl/u_seqdiv_rst.sv - iterative unsigned restoring divider, one quotient bit per clock (optional TRUNC_QUOTIENT_EN)
module u_seqdiv_rst #(
  parameter int N     = 8,
  parameter int TRUNC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

`ifdef TRUNC_QUOTIENT_EN
  // Low quotient iterations are skipped; the missing bits read back as zero.
  localparam int SKIP = TRUNC;
`else
  // Exact build: every quotient bit is computed, TRUNC has no effect.
  localparam int SKIP = 0 * TRUNC;
`endif

  localparam int ITER = N - SKIP;
  localparam int CW   = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   q_reg;
  logic [N-1:0]   d_reg;
  logic [N-1:0]   r_reg;
  logic [CW-1:0]  cnt;

  logic [N:0]     t_val;
  logic [N:0]     s_val;
  logic [N-1:0]   r_next;
  logic [N-1:0]   q_next;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    t_val  = {r_reg, q_reg[N-1]};
    s_val  = t_val - {1'b0, d_reg};
    r_next = t_val[N-1:0];
    q_next = {q_reg[N-2:0], 1'b0};
    if (!s_val[N]) begin
      r_next = s_val[N-1:0];
      q_next = {q_reg[N-2:0], 1'b1};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg       <= dividend;
            d_reg       <= divisor;
            r_reg       <= '0;
            cnt         <= CW'(ITER);
            in_ready    <= 1'b0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor bypasses the iterations entirely.
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next << SKIP;
            remainder <= r_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/u_seqdiv_rst.md
Name: u_seqdiv_rst

Overview:
- Iterative unsigned restoring divider: the inverse operation of the team's unsigned array multipliers (the BAM family).
- Accepts an N-bit dividend and an N-bit divisor; produces an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Valid/ready handshakes on both sides so it drops into datapaths next to the generated multiplier/adder blocks.
- Optional build macro truncates the low quotient iterations, giving an approximate divider in the same spirit as the broken-array multipliers.

Parameters:
- N, 8, operand/quotient/remainder width (N >= 2).
- TRUNC, 2, low quotient iterations skipped when TRUNC_QUOTIENT_EN is defined (0 <= TRUNC < N); ignored otherwise.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- States:
  - IDLE: in_ready=1.
    - On in_valid at a rising edge (accept edge), latch dividend into Q, divisor into D, clear R to 0, load counter with ITER.
    - If divisor==0, go straight to DONE with quotient={N{1}}, remainder=dividend, div_by_zero=1 (out_valid 1 cycle after accept).
    - Otherwise go to CALC.
  - CALC: in_ready=0. Each edge computes:
    - T = {R, Q[N-1]} (N+1 bits); S = T - {1'b0, D}.
    - If S >= 0 (no borrow): R=S[N-1:0], Q={Q[N-2:0],1}; else R=T[N-1:0], Q={Q[N-2:0],0}.
    - Decrement counter. When the edge processes the last iteration (counter==1), go to DONE.
  - DONE: out_valid=1, in_ready=0.
    - Outputs are held stable while out_ready=0.
    - On out_valid & out_ready, go to IDLE and clear out_valid.
- ITER = N (no macro).
- Latency: out_valid rises ITER edges after the accept edge (8 for N=8). Zero-divisor path takes 1 edge.
- Throughput: one operation in flight. in_ready is 0 from the accept edge until the DONE handshake edge. No same-cycle DONE-to-accept bypass, so back-to-back issue costs 1 extra IDLE cycle.
- div_by_zero clears when the next operation is accepted.
- Internal widths: R is N bits, subtraction is N+1 bits. No overflow is possible because the remainder is always < D.
- Edge operands:
  - dividend=0 gives q=0, r=0.
  - divisor=1 gives q=dividend, r=0.
  - dividend<divisor gives q=0, r=dividend.
- Reset mid-operation: returns to IDLE immediately with reset values. The partial result is discarded and no out_valid is produced.
- in_valid while busy is ignored, and the operands are not latched.
- Inputs are not required to be stable after the accept edge.

Optional Feature:
- Macro: TRUNC_QUOTIENT_EN.
- Defined:
  - ITER = N-TRUNC; the first N-TRUNC iterations run normally.
  - quotient = {Q[N-TRUNC-1:0], TRUNC'b0}, i.e. floor(dividend/(divisor*2^TRUNC))*2^TRUNC.
  - remainder = floor(dividend/2^TRUNC) mod divisor (the partial R). It is non-exact by design.
  - Latency is N-TRUNC edges. The zero-divisor path is unchanged.
- Undefined: exact division, TRUNC unused, ITER=N.

Test Plan:
- N=8, dividend=200, divisor=7 -> quotient=28, remainder=4, div_by_zero=0; out_valid exactly 8 edges after accept.
- dividend=0xA5, divisor=0 -> quotient=0xFF, remainder=0xA5, div_by_zero=1, out_valid 1 edge after accept; the next valid op clears div_by_zero.
- dividend=5, divisor=9 then dividend=255, divisor=1, back-to-back with out_ready=1 -> (0,5) then (255,0); in_ready stays low during CALC; in_valid pulses during CALC are ignored.
- out_ready held 0 for 5 cycles in DONE after 100/10 -> quotient=10, remainder=0 held stable, out_valid=1, in_ready=0; handshake then returns to IDLE.
- Assert rst_n=0 on the 4th CALC edge of 200/7 -> all outputs go to reset values asynchronously; no out_valid; a following 9/3 gives (3,0).
- With TRUNC_QUOTIENT_EN, TRUNC=2: 200/3 -> quotient=64, remainder=2, latency 6 edges; 255/255 -> quotient=0, remainder=63.
